// File: rtl/adc_spi_rx_pkg.sv
// Shared defaults and width helpers for the ADC SPI receiver.
`timescale 1ns/1ps
package adc_spi_rx_pkg;

  localparam int DATA_WIDTH_DEF     = 16;
  localparam int TIMEOUT_CYCLES_DEF = 1024;
  localparam int SYNC_STAGES_DEF    = 2;

  // Width of a counter that must be able to hold max_val itself.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  localparam int IDLE_CNT_W_DEF = cnt_width(TIMEOUT_CYCLES_DEF);

endpackage

// File: rtl/adc_spi_rx_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with rise/fall detection
// against one extra delayed copy of the synchronised level.
`timescale 1ns/1ps
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Shift the raw input through the synchroniser chain and keep the previous level.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/adc_spi_rx.sv
// Receive-only SPI slave: deserialises LSB-first ADC words, strobes each
// complete word, and drops partial frames after an SCK idle timeout.
`timescale 1ns/1ps
module adc_spi_rx
  import adc_spi_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  spi_clock_in,
  input  logic                  spi_data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_received
);

  localparam int IDLE_W = cnt_width(TIMEOUT_CYCLES);
  localparam int BIT_W  = $clog2(DATA_WIDTH);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  logic w_sck_rise;
  logic w_sck_fall;
  logic w_unused_sck_level;
  logic w_sdi;
  logic w_unused_sdi_rise;
  logic w_unused_sdi_fall;

  // The final bit goes straight into data_out, so only DATA_WIDTH-1 bits are held.
  logic [DATA_WIDTH-2:0] r_shift;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [IDLE_W-1:0]     r_idle;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_strobe;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clock   (clock),
    .reset   (reset),
    .i_async (spi_clock_in),
    .o_level (w_unused_sck_level),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sdi_sync (
    .clock   (clock),
    .reset   (reset),
    .i_async (spi_data_in),
    .o_level (w_sdi),
    .o_rise  (w_unused_sdi_rise),
    .o_fall  (w_unused_sdi_fall)
  );

  // Idle counter: any SCK edge restarts it, otherwise it saturates at the timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_idle <= '0;
    end else if (w_sck_rise || w_sck_fall) begin
      r_idle <= '0;
    end else if (r_idle != IDLE_MAX) begin
      r_idle <= r_idle + IDLE_W'(1);
    end else begin
      r_idle <= r_idle;
    end
  end

  // Bit capture, word hand-off and timeout discard; a rising edge beats the timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_data_out <= '0;
      r_strobe   <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (w_sck_rise) begin
        if (r_bit_cnt == BIT_LAST) begin
          r_data_out <= {w_sdi, r_shift};
          r_strobe   <= 1'b1;
          r_bit_cnt  <= '0;
          r_shift    <= '0;
        end else begin
          r_shift   <= {w_sdi, r_shift[DATA_WIDTH-2:1]};
          r_bit_cnt <= r_bit_cnt + BIT_W'(1);
        end
      end else if ((r_idle == IDLE_MAX) && (r_bit_cnt != '0)) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end else begin
        r_shift   <= r_shift;
        r_bit_cnt <= r_bit_cnt;
      end
    end
  end

  assign data_out      = r_data_out;
  assign data_received = r_strobe;

endmodule

// File: tb/tb_adc_spi_rx.sv
// Self-checking bench for adc_spi_rx: table of SPI frames plus hand-written
// reset/timeout sequences, with a strobe-driven scoreboard.
`timescale 1ns/1ps
module tb_adc_spi_rx;

  logic        clock;
  logic        reset;
  logic        spi_clock_in;
  logic        spi_data_in;
  logic [15:0] data_out;
  logic        data_received;

  adc_spi_rx dut (
    .clock         (clock),
    .reset         (reset),
    .spi_clock_in  (spi_clock_in),
    .spi_data_in   (spi_data_in),
    .data_out      (data_out),
    .data_received (data_received)
  );

  initial clock = 1'b0;
  always #3.75 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] word;
    int          nbits;
    int          hp;
    int          gap;
  } vec_t;

  vec_t        vecs[7];
  logic [15:0] exp_q[$];
  int          rise_q[$];
  logic [15:0] exp_dout;
  int          n_checks = 0;
  int          n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Sends nbits of w LSB first; data changes while SCK is low, SCK idles low.
  task automatic send(input logic [15:0] w, input int nbits, input int hp);
    for (int b = 0; b < nbits; b++) begin
      spi_data_in = w[b];
      repeat (hp) @(posedge clock);
      #1 spi_clock_in = 1'b1;
      if (b == 15) rise_q.push_back(cyc);
      repeat (hp) @(posedge clock);
      #1 spi_clock_in = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
  endtask

  initial begin
    logic [15:0] e;
    logic        prev_strobe;
    logic [15:0] prev_dout;
    int          lat;

    vecs[0] = '{16'hAACC, 16, 50, 200};
    vecs[1] = '{16'h96AA, 15, 50, 1340};
    vecs[2] = '{16'hAACC, 16, 50, 13340};
    vecs[3] = '{16'h1655, 16, 50, 100};
    vecs[4] = '{16'hFFFF, 16, 4, 0};
    vecs[5] = '{16'h0001, 16, 4, 100};
    vecs[6] = '{16'h8001, 16, 7, 100};

    reset        = 1'b1;
    spi_clock_in = 1'b0;
    spi_data_in  = 1'b0;
    exp_dout     = 16'h0000;
    prev_strobe  = 1'b0;
    prev_dout    = 16'h0000;

    fork
      forever begin
        @(negedge clock);
        if (reset) begin
          prev_strobe = 1'b0;
          prev_dout   = data_out;
        end else begin
          if (data_received) begin
            check("strobe_width_prev_low", {31'd0, prev_strobe}, 32'd0);
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fails++;
              $display("FAIL unexpected_strobe: data_out=0x%0h, expected no strobe", data_out);
            end else begin
              e = exp_q.pop_front();
              check("word", {16'd0, data_out}, {16'd0, e});
              lat = (rise_q.size() != 0) ? (cyc - rise_q.pop_front()) : -1;
              n_checks++;
              if (lat < 1 || lat > 4) begin
                n_fails++;
                $display("FAIL latency: got %0d clocks, expected 1..4", lat);
              end
            end
          end else if (data_out !== prev_dout) begin
            n_checks++;
            n_fails++;
            $display("FAIL dout_changed: got 0x%0h without strobe, expected 0x%0h", data_out, prev_dout);
          end
          prev_strobe = data_received;
          prev_dout   = data_out;
        end
      end
    join_none

    // Reset held ~20 ns, then observe a quiet idle link.
    idle(3);
    #1 reset = 1'b0;
    idle(50);
    @(negedge clock);
    check("reset_data_out", {16'd0, data_out}, 32'd0);
    check("reset_strobe", {31'd0, data_received}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].nbits == 16) begin
        exp_q.push_back(vecs[i].word);
        exp_dout = vecs[i].word;
      end
      send(vecs[i].word, vecs[i].nbits, vecs[i].hp);
      idle(vecs[i].gap);
      @(negedge clock);
      check($sformatf("dout_after_vec%0d", i), {16'd0, data_out}, {16'd0, exp_dout});
    end

    // Reset mid-frame: 8 bits of 0x5A5A are aborted, then 0x1234 arrives whole.
    send(16'h5A5A, 8, 50);
    idle(10);
    #1 reset = 1'b1;
    idle(3);
    #1 reset = 1'b0;
    idle(20);
    @(negedge clock);
    check("dout_after_midframe_reset", {16'd0, data_out}, 32'd0);
    exp_q.push_back(16'h1234);
    send(16'h1234, 16, 50);
    idle(100);
    @(negedge clock);
    check("dout_after_reset_frame", {16'd0, data_out}, 32'h1234);

    check("pending_strobes", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fails, n_checks);
    $finish;
  end

endmodule
